stopwatch_time_counter: RTL and testbench

STOPWATCH_TIME_COUNTER -- requirements
Module: stopwatch_time_counter

---
 rtl/sw_time_pkg.sv | 22 ++
 rtl/sw_mod_counter.sv | 48 ++++
 rtl/stopwatch_time_counter.sv | 134 +++++++++++++
 tb/tb_stopwatch_time_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_time_pkg.sv
// Shared field widths, default terminal values and the time-of-day record
// used by the stopwatch time counter and its field counters.
package sw_time_pkg;

   localparam int MS_W  = 7;
   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HR_W  = 5;

   localparam int MS_MAX_DEF  = 99;
   localparam int SEC_MAX_DEF = 59;
   localparam int MIN_MAX_DEF = 59;
   localparam int HR_MAX_DEF  = 23;

   typedef struct packed {
      logic [HR_W-1:0]  hr;
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
      logic [MS_W-1:0]  ms;
   } sw_time_t;

endpackage

// File: rtl/sw_mod_counter.sv
// One time field: a mod-(MAX+1) up/down counter that only moves on tick.
// Out-of-range values recover toward the range: up loads 0, down loads MAX.
module sw_mod_counter #(
   parameter int WIDTH = 7,
   parameter int MAX   = 99
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clear,
   input  logic             i_tick,
   input  logic             i_up,
   input  logic             i_down,
   output logic [WIDTH-1:0] o_value,
   output logic             o_at_max,
   output logic             o_at_zero
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] value_nxt;

   // Next value: clear first, then a single-direction step on tick, else hold.
   always_comb begin
      value_nxt = value;
      if (i_clear) begin
         value_nxt = '0;
      end else if (i_tick && i_up && !i_down) begin
         value_nxt = (value >= MAX_V) ? '0 : value + WIDTH'(1);
      end else if (i_tick && i_down && !i_up) begin
         value_nxt = ((value == '0) || (value > MAX_V)) ? MAX_V : value - WIDTH'(1);
      end
   end

   // Field register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         value <= '0;
      end else begin
         value <= value_nxt;
      end
   end

   assign o_value   = value;
   assign o_at_max  = (value == MAX_V);
   assign o_at_zero = (value == '0);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time counter: four independent field counters plus lap capture,
// sticky hours overflow and synchronous clear. Cascading between fields is
// done by the caller gating each up request with the lower field's carry.
module stopwatch_time_counter
   import sw_time_pkg::*;
#(
   parameter int MS_MAX  = MS_MAX_DEF,
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int MIN_MAX = MIN_MAX_DEF,
   parameter int HR_MAX  = HR_MAX_DEF
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_tick,
   input  logic             i_clear,
   input  logic             i_lap,
   input  logic             i_ms_up,
   input  logic             i_ms_down,
   input  logic             i_sec_up,
   input  logic             i_sec_down,
   input  logic             i_min_up,
   input  logic             i_min_down,
   input  logic             i_hr_up,
   input  logic             i_hr_down,
   output logic [MS_W-1:0]  o_ms,
   output logic [SEC_W-1:0] o_sec,
   output logic [MIN_W-1:0] o_min,
   output logic [HR_W-1:0]  o_hr,
   output logic             o_ms_carryup,
   output logic             o_sec_carryup,
   output logic             o_min_carryup,
   output logic             o_hr_carryup,
   output logic             o_ms_borrow,
   output logic             o_sec_borrow,
   output logic             o_min_borrow,
   output logic             o_hr_borrow,
   output logic [MS_W-1:0]  o_lap_ms,
   output logic [SEC_W-1:0] o_lap_sec,
   output logic [MIN_W-1:0] o_lap_min,
   output logic [HR_W-1:0]  o_lap_hr,
   output logic             o_lap_valid,
   output logic             o_overflow
);

   sw_time_t now;
   sw_time_t lap_q;
   logic     lap_valid_q;
   logic     overflow_q;
   logic     hr_wrap_up;

   sw_mod_counter #(.WIDTH(MS_W), .MAX(MS_MAX)) u_ms (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clear   (i_clear),
      .i_tick    (i_tick),
      .i_up      (i_ms_up),
      .i_down    (i_ms_down),
      .o_value   (now.ms),
      .o_at_max  (o_ms_carryup),
      .o_at_zero (o_ms_borrow)
   );

   sw_mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clear   (i_clear),
      .i_tick    (i_tick),
      .i_up      (i_sec_up),
      .i_down    (i_sec_down),
      .o_value   (now.sec),
      .o_at_max  (o_sec_carryup),
      .o_at_zero (o_sec_borrow)
   );

   sw_mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clear   (i_clear),
      .i_tick    (i_tick),
      .i_up      (i_min_up),
      .i_down    (i_min_down),
      .o_value   (now.min),
      .o_at_max  (o_min_carryup),
      .o_at_zero (o_min_borrow)
   );

   sw_mod_counter #(.WIDTH(HR_W), .MAX(HR_MAX)) u_hr (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clear   (i_clear),
      .i_tick    (i_tick),
      .i_up      (i_hr_up),
      .i_down    (i_hr_down),
      .o_value   (now.hr),
      .o_at_max  (o_hr_carryup),
      .o_at_zero (o_hr_borrow)
   );

   // Hours steps up from its terminal value this cycle.
   assign hr_wrap_up = i_tick && i_hr_up && !i_hr_down && o_hr_carryup;

   // Lap capture and sticky overflow; clear overrides both.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         lap_q       <= '0;
         lap_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (i_clear) begin
         lap_q       <= '0;
         lap_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (i_lap) begin
            lap_q       <= now;
            lap_valid_q <= 1'b1;
         end
         if (hr_wrap_up) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign o_ms        = now.ms;
   assign o_sec       = now.sec;
   assign o_min       = now.min;
   assign o_hr        = now.hr;
   assign o_lap_ms    = lap_q.ms;
   assign o_lap_sec   = lap_q.sec;
   assign o_lap_min   = lap_q.min;
   assign o_lap_hr    = lap_q.hr;
   assign o_lap_valid = lap_valid_q;
   assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: stimulus pushes hand-computed
// expected snapshots into a queue; a monitor pops and compares them.
module tb_stopwatch_time_counter;

   typedef struct packed {
      logic [6:0] ms;
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hr;
      logic [3:0] carry;
      logic [3:0] borrow;
      logic [6:0] lms;
      logic [5:0] lsec;
      logic [5:0] lmin;
      logic [4:0] lhr;
      logic       lv;
      logic       ov;
   } exp_t;

   localparam logic [7:0] MS_U  = 8'h80;
   localparam logic [7:0] MS_D  = 8'h40;
   localparam logic [7:0] SEC_U = 8'h20;
   localparam logic [7:0] SEC_D = 8'h10;
   localparam logic [7:0] MIN_U = 8'h08;
   localparam logic [7:0] MIN_D = 8'h04;
   localparam logic [7:0] HR_U  = 8'h02;
   localparam logic [7:0] HR_D  = 8'h01;

   logic       i_clk, i_rstn, i_tick, i_clear, i_lap;
   logic [7:0] ud;
   logic [6:0] o_ms, o_lap_ms;
   logic [5:0] o_sec, o_min, o_lap_sec, o_lap_min;
   logic [4:0] o_hr, o_lap_hr;
   logic       o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup;
   logic       o_ms_borrow, o_sec_borrow, o_min_borrow, o_hr_borrow;
   logic       o_lap_valid, o_overflow;

   exp_t  act;
   exp_t  exp_q[$];
   string name_q[$];
   event  sample_ev;
   int    n_checks = 0;
   int    n_errors = 0;

   stopwatch_time_counter dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_tick        (i_tick),
      .i_clear       (i_clear),
      .i_lap         (i_lap),
      .i_ms_up       (ud[7]),
      .i_ms_down     (ud[6]),
      .i_sec_up      (ud[5]),
      .i_sec_down    (ud[4]),
      .i_min_up      (ud[3]),
      .i_min_down    (ud[2]),
      .i_hr_up       (ud[1]),
      .i_hr_down     (ud[0]),
      .o_ms          (o_ms),
      .o_sec         (o_sec),
      .o_min         (o_min),
      .o_hr          (o_hr),
      .o_ms_carryup  (o_ms_carryup),
      .o_sec_carryup (o_sec_carryup),
      .o_min_carryup (o_min_carryup),
      .o_hr_carryup  (o_hr_carryup),
      .o_ms_borrow   (o_ms_borrow),
      .o_sec_borrow  (o_sec_borrow),
      .o_min_borrow  (o_min_borrow),
      .o_hr_borrow   (o_hr_borrow),
      .o_lap_ms      (o_lap_ms),
      .o_lap_sec     (o_lap_sec),
      .o_lap_min     (o_lap_min),
      .o_lap_hr      (o_lap_hr),
      .o_lap_valid   (o_lap_valid),
      .o_overflow    (o_overflow)
   );

   assign act = {o_ms, o_sec, o_min, o_hr,
                 o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup,
                 o_ms_borrow, o_sec_borrow, o_min_borrow, o_hr_borrow,
                 o_lap_ms, o_lap_sec, o_lap_min, o_lap_hr, o_lap_valid, o_overflow};

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Expected snapshot from hand-picked field values (default MAX 99/59/59/23).
   function automatic exp_t mk(input int ms, input int sec, input int mn, input int hr,
                               input int lms, input int lsec, input int lmin, input int lhr,
                               input logic lv, input logic ov);
      exp_t e;
      e.ms     = 7'(ms);
      e.sec    = 6'(sec);
      e.min    = 6'(mn);
      e.hr     = 5'(hr);
      e.carry  = {ms == 99, sec == 59, mn == 59, hr == 23};
      e.borrow = {ms == 0, sec == 0, mn == 0, hr == 0};
      e.lms    = 7'(lms);
      e.lsec   = 6'(lsec);
      e.lmin   = 6'(lmin);
      e.lhr    = 5'(lhr);
      e.lv     = lv;
      e.ov     = ov;
      return e;
   endfunction

   task automatic step(input string nm, input logic tick, input logic clr, input logic lap,
                       input logic [7:0] req, input exp_t e);
      @(negedge i_clk);
      i_tick  = tick;
      i_clear = clr;
      i_lap   = lap;
      ud      = req;
      @(posedge i_clk);
      #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic idle();
      @(negedge i_clk);
      i_tick  = 1'b0;
      i_clear = 1'b0;
      i_lap   = 1'b0;
      ud      = '0;
   endtask

   // Monitor: compare queued expectations at the falling edge or on demand.
   initial begin
      forever begin
         @(negedge i_clk or sample_ev);
         while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
               n_errors++;
               $display("FAIL %s: got ms=%0d sec=%0d min=%0d hr=%0d cy=%b bw=%b lap=%0d:%0d:%0d.%0d lv=%b ov=%b, expected ms=%0d sec=%0d min=%0d hr=%0d cy=%b bw=%b lap=%0d:%0d:%0d.%0d lv=%b ov=%b",
                        nm, act.ms, act.sec, act.min, act.hr, act.carry, act.borrow,
                        act.lhr, act.lmin, act.lsec, act.lms, act.lv, act.ov,
                        e.ms, e.sec, e.min, e.hr, e.carry, e.borrow,
                        e.lhr, e.lmin, e.lsec, e.lms, e.lv, e.ov);
            end
         end
      end
   end

   initial begin
      i_rstn  = 1'b0;
      i_tick  = 1'b0;
      i_clear = 1'b0;
      i_lap   = 1'b0;
      ud      = '0;
      #2;
      exp_q.push_back(mk(0,0,0,0, 0,0,0,0, 0,0));
      name_q.push_back("reset_state");
      ->sample_ev;
      #10 i_rstn = 1'b1;

      step("tick_gate",     0, 0, 0, MS_U,                 mk( 0, 0, 0, 0, 0,0,0,0, 0,0));
      step("ms_inc",        1, 0, 0, MS_U,                 mk( 1, 0, 0, 0, 0,0,0,0, 0,0));
      step("ms_up_and_dn",  1, 0, 0, MS_U|MS_D,            mk( 1, 0, 0, 0, 0,0,0,0, 0,0));
      step("ms_dec",        1, 0, 0, MS_D,                 mk( 0, 0, 0, 0, 0,0,0,0, 0,0));
      step("ms_wrap_dn",    1, 0, 0, MS_D,                 mk(99, 0, 0, 0, 0,0,0,0, 0,0));
      step("sec_wrap_dn",   1, 0, 0, SEC_D,                mk(99,59, 0, 0, 0,0,0,0, 0,0));
      step("cascade_min",   1, 0, 0, MS_U|SEC_U|MIN_U,     mk( 0, 0, 1, 0, 0,0,0,0, 0,0));
      step("hr_wrap_dn",    1, 0, 0, HR_D,                 mk( 0, 0, 1,23, 0,0,0,0, 0,0));
      step("min_dec",       1, 0, 0, MIN_D,                mk( 0, 0, 0,23, 0,0,0,0, 0,0));
      step("min_wrap_dn",   1, 0, 0, MIN_D,                mk( 0, 0,59,23, 0,0,0,0, 0,0));
      step("sec_wrap_dn2",  1, 0, 0, SEC_D,                mk( 0,59,59,23, 0,0,0,0, 0,0));
      step("ms_wrap_dn2",   1, 0, 0, MS_D,                 mk(99,59,59,23, 0,0,0,0, 0,0));
      step("full_cascade",  1, 0, 0, MS_U|SEC_U|MIN_U|HR_U,mk( 0, 0, 0, 0, 0,0,0,0, 0,1));
      step("ovf_sticky",    1, 0, 0, MS_U,                 mk( 1, 0, 0, 0, 0,0,0,0, 0,1));
      step("clear",         1, 1, 0, MS_U,                 mk( 0, 0, 0, 0, 0,0,0,0, 0,0));
      step("set_a",         1, 0, 0, MS_U|SEC_U|MIN_U,     mk( 1, 1, 1, 0, 0,0,0,0, 0,0));
      step("set_b",         1, 0, 0, MS_U|SEC_U,           mk( 2, 2, 1, 0, 0,0,0,0, 0,0));
      step("set_c",         1, 0, 0, MS_U,                 mk( 3, 2, 1, 0, 0,0,0,0, 0,0));
      step("lap_capture",   1, 0, 1, MS_U,                 mk( 4, 2, 1, 0, 3,2,1,0, 1,0));
      step("lap_overwrite", 0, 0, 1, MS_U,                 mk( 4, 2, 1, 0, 4,2,1,0, 1,0));
      step("lap_clear",     1, 1, 1, MS_U,                 mk( 0, 0, 0, 0, 0,0,0,0, 0,0));
      step("pre_rst_1",     1, 0, 0, MS_U,                 mk( 1, 0, 0, 0, 0,0,0,0, 0,0));
      step("pre_rst_2",     1, 0, 1, MS_U,                 mk( 2, 0, 0, 0, 1,0,0,0, 1,0));
      step("pre_rst_hold",  0, 0, 0, 8'h00,                mk( 2, 0, 0, 0, 1,0,0,0, 1,0));
      idle();

      // Asynchronous reset pulse between clock edges.
      @(posedge i_clk);
      #3 i_rstn = 1'b0;
      #1;
      exp_q.push_back(mk(0,0,0,0, 0,0,0,0, 0,0));
      name_q.push_back("async_reset");
      ->sample_ev;
      #2 i_rstn = 1'b1;

      step("resume",        1, 0, 0, MS_U,                 mk( 1, 0, 0, 0, 0,0,0,0, 0,0));
      step("resume_hold",   0, 0, 0, 8'h00,                mk( 1, 0, 0, 0, 0,0,0,0, 0,0));
      idle();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge i_clk);
      if (exp_q.size() > 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
